axi2mem_trans_arbiter: RTL and testbench

Shares the single 2-lane TCDM command/response port between the axi2mem read and write channels. Whole bursts are granted atomically, bursts alternate round-robin, and each command is tagged with its owner so memory responses route back to the issuing channel. The block sits between the read/write channel blocks and the TCDM command queues.

---
 rtl/axi2mem_pkg.sv | 21 ++
 rtl/axi2mem_sat_counter.sv | 24 ++
 rtl/axi2mem_trans_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi2mem_trans_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// Shared types and constants for the axi2mem TCDM arbitration slice.
package axi2mem_pkg;

    typedef enum logic {
        ARB_UNLOCKED,
        ARB_LOCKED
    } arb_state_e;

    localparam logic OWNER_RD = 1'b0;
    localparam logic OWNER_WR = 1'b1;

    localparam int unsigned AXI2MEM_ADDR_W = 32;
    localparam int unsigned AXI2MEM_ID_W   = 6;

    typedef struct packed {
        logic [AXI2MEM_ADDR_W-1:0] add;
        logic [AXI2MEM_ID_W-1:0]   id;
        logic                      last;
    } trans_lane_t;

endpackage

// File: rtl/axi2mem_sat_counter.sv
// 32-bit event counter that sticks at all-ones; clear wins over enable.
module axi2mem_sat_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi2mem_trans_arbiter.sv
// Burst-atomic round-robin share of one 2-lane TCDM port between read and write channels.
// Optional performance counters are built when AXI2MEM_ARB_PERF_EN is defined.
module axi2mem_trans_arbiter
    import axi2mem_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [1:0]                           pend_i,
    input  logic [1:0][1:0]                      req_i,
    input  logic [1:0][1:0][ADDR_WIDTH-1:0]      add_i,
    input  logic [1:0][1:0][ID_WIDTH-1:0]        id_i,
    input  logic [1:0][1:0]                      last_i,
    output logic [1:0][1:0]                      gnt_o,
    output logic [1:0]                           m_req_o,
    output logic [1:0][ADDR_WIDTH-1:0]           m_add_o,
    output logic [1:0][ID_WIDTH-1:0]             m_id_o,
    output logic [1:0]                           m_last_o,
    input  logic [1:0]                           m_gnt_i,
    input  logic                                 m_r_req_i,
    input  logic [ID_WIDTH-1:0]                  m_r_id_i,
    output logic                                 m_r_gnt_o,
    output logic [1:0]                           r_req_o,
    output logic [1:0][ID_WIDTH-1:0]             r_id_o,
    input  logic [1:0]                           r_gnt_i
`ifdef AXI2MEM_ARB_PERF_EN
    ,
    input  logic                                 perf_clr_i,
    output logic [1:0][31:0]                     perf_beats_o,
    output logic [31:0]                          perf_stall_o
`endif
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       peer;
    logic       xfer;
    logic       r_sel;

    assign peer = ~owner_q;
    assign xfer = (m_req_o == 2'b11) && (m_gnt_i == 2'b11);

    // Forward the owner's lanes; ID MSB carries the owner tag.
    always_comb begin
        m_req_o  = '0;
        m_add_o  = '0;
        m_id_o   = '0;
        m_last_o = '0;
        gnt_o    = '0;
        for (int unsigned l = 0; l < 2; l++) begin
            m_req_o[l]             = req_i[owner_q][l];
            m_add_o[l]             = add_i[owner_q][l];
            m_last_o[l]            = last_i[owner_q][l];
            m_id_o[l]              = id_i[owner_q][l];
            m_id_o[l][ID_WIDTH-1]  = owner_q;
            gnt_o[OWNER_RD][l]     = m_gnt_i[l] & (owner_q == OWNER_RD);
            gnt_o[OWNER_WR][l]     = m_gnt_i[l] & (owner_q == OWNER_WR);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_UNLOCKED: begin
                if (xfer) begin
                    if (!m_last_o[0]) begin
                        state_d = ARB_LOCKED;
                    end else if (pend_i[peer]) begin
                        owner_d = peer;
                    end
                end else if (!pend_i[owner_q] && pend_i[peer]) begin
                    owner_d = peer;
                end
            end
            ARB_LOCKED: begin
                if (xfer && m_last_o[0]) begin
                    state_d = ARB_UNLOCKED;
                    if (pend_i[peer]) begin
                        owner_d = peer;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_UNLOCKED;
            owner_q <= OWNER_RD;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Responses return to whichever channel the tag bit names.
    assign r_sel = m_r_id_i[ID_WIDTH-1];

    always_comb begin
        r_req_o        = '0;
        r_req_o[r_sel] = m_r_req_i;
        for (int unsigned i = 0; i < 2; i++) begin
            r_id_o[i]             = m_r_id_i;
            r_id_o[i][ID_WIDTH-1] = 1'b0;
        end
        m_r_gnt_o = r_gnt_i[r_sel];
    end

`ifdef AXI2MEM_ARB_PERF_EN
    logic stall;
    assign stall = pend_i[peer];

    axi2mem_sat_counter u_beats_rd (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (perf_clr_i),
        .en_i   (xfer && (owner_q == OWNER_RD)),
        .cnt_o  (perf_beats_o[0])
    );

    axi2mem_sat_counter u_beats_wr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (perf_clr_i),
        .en_i   (xfer && (owner_q == OWNER_WR)),
        .cnt_o  (perf_beats_o[1])
    );

    axi2mem_sat_counter u_stall (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (perf_clr_i),
        .en_i   (stall),
        .cnt_o  (perf_stall_o)
    );
`endif

endmodule

// File: tb/tb_axi2mem_trans_arbiter.sv
// Directed bench for axi2mem_trans_arbiter; perf checks build with AXI2MEM_ARB_PERF_EN.
module tb_axi2mem_trans_arbiter;

    logic                  clk_i;
    logic                  rst_ni;
    logic [1:0]            pend_i;
    logic [1:0][1:0]       req_i;
    logic [1:0][1:0][31:0] add_i;
    logic [1:0][1:0][5:0]  id_i;
    logic [1:0][1:0]       last_i;
    logic [1:0][1:0]       gnt_o;
    logic [1:0]            m_req_o;
    logic [1:0][31:0]      m_add_o;
    logic [1:0][5:0]       m_id_o;
    logic [1:0]            m_last_o;
    logic [1:0]            m_gnt_i;
    logic                  m_r_req_i;
    logic [5:0]            m_r_id_i;
    logic                  m_r_gnt_o;
    logic [1:0]            r_req_o;
    logic [1:0][5:0]       r_id_o;
    logic [1:0]            r_gnt_i;
`ifdef AXI2MEM_ARB_PERF_EN
    logic                  perf_clr_i;
    logic [1:0][31:0]      perf_beats_o;
    logic [31:0]           perf_stall_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    axi2mem_trans_arbiter #(.ID_WIDTH(6), .ADDR_WIDTH(32)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .pend_i    (pend_i),
        .req_i     (req_i),
        .add_i     (add_i),
        .id_i      (id_i),
        .last_i    (last_i),
        .gnt_o     (gnt_o),
        .m_req_o   (m_req_o),
        .m_add_o   (m_add_o),
        .m_id_o    (m_id_o),
        .m_last_o  (m_last_o),
        .m_gnt_i   (m_gnt_i),
        .m_r_req_i (m_r_req_i),
        .m_r_id_i  (m_r_id_i),
        .m_r_gnt_o (m_r_gnt_o),
        .r_req_o   (r_req_o),
        .r_id_o    (r_id_o),
        .r_gnt_i   (r_gnt_i)
`ifdef AXI2MEM_ARB_PERF_EN
        ,
        .perf_clr_i   (perf_clr_i),
        .perf_beats_o (perf_beats_o),
        .perf_stall_o (perf_stall_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        pend_i = '0;
        req_i  = '0;
        last_i = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        m_gnt_i = 2'b11;
        req_i[0] = 2'b01;
        req_i[1] = 2'b10;
        add_i[0][0] = 32'h0000_1000;
        add_i[1][0] = 32'h0000_2000;
        id_i[0][0] = 6'b111111;
        repeat (2) tick();
        n_tests++;
        if (gnt_o !== 4'b0011) begin n_fail++; $display("FAIL rst_gnt: got %b expected %b", gnt_o, 4'b0011); end
        n_tests++;
        if (m_req_o !== 2'b01) begin n_fail++; $display("FAIL rst_m_req: got %b expected %b", m_req_o, 2'b01); end
        n_tests++;
        if (m_add_o[0] !== 32'h0000_1000) begin n_fail++; $display("FAIL rst_m_add: got %h expected %h", m_add_o[0], 32'h0000_1000); end
        n_tests++;
        if (m_id_o[0] !== 6'b011111) begin n_fail++; $display("FAIL rst_m_id: got %b expected %b", m_id_o[0], 6'b011111); end
`ifdef AXI2MEM_ARB_PERF_EN
        n_tests++;
        if (perf_beats_o !== 64'd0 || perf_stall_o !== 32'd0) begin
            n_fail++; $display("FAIL rst_perf: got %h/%h expected 0/0", perf_beats_o, perf_stall_o);
        end
`endif
        clear_inputs();
        rst_ni = 1'b1;
        tick();
    endtask

    // Owner 0 idle, write pending: one idle switch cycle then write beat.
    task automatic test_write_single();
        pend_i = 2'b10;
        req_i[1] = 2'b11;
        last_i[1] = 2'b11;
        id_i[1][0] = 6'h05;
        id_i[1][1] = 6'h05;
        #1;
        n_tests++;
        if (gnt_o !== 4'b0011) begin n_fail++; $display("FAIL wr_idle_gnt: got %b expected %b", gnt_o, 4'b0011); end
        tick();
        n_tests++;
        if (gnt_o !== 4'b1100) begin n_fail++; $display("FAIL wr_gnt: got %b expected %b", gnt_o, 4'b1100); end
        n_tests++;
        if (m_id_o[0] !== 6'b100101) begin n_fail++; $display("FAIL wr_m_id: got %b expected %b", m_id_o[0], 6'b100101); end
        n_tests++;
        if (m_req_o !== 2'b11) begin n_fail++; $display("FAIL wr_m_req: got %b expected %b", m_req_o, 2'b11); end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (gnt_o !== 4'b1100) begin n_fail++; $display("FAIL wr_hold_owner: got %b expected %b", gnt_o, 4'b1100); end
    endtask

    // 4-beat read burst; write pending from beat 1 must wait for the last beat.
    task automatic test_read_burst();
        pend_i = 2'b01;
        req_i[0] = 2'b11;
        last_i[0] = 2'b00;
        #1;
        n_tests++;
        if (gnt_o !== 4'b1100) begin n_fail++; $display("FAIL rd_switch_idle: got %b expected %b", gnt_o, 4'b1100); end
        tick();
        pend_i = 2'b11;
        req_i[1] = 2'b11;
        last_i[1] = 2'b11;
        for (int b = 1; b <= 4; b++) begin
            if (b == 4) last_i[0] = 2'b11;
            #1;
            n_tests++;
            if (gnt_o !== 4'b0011) begin n_fail++; $display("FAIL rd_beat%0d_gnt: got %b expected %b", b, gnt_o, 4'b0011); end
            tick();
        end
        req_i[0] = 2'b00;
        pend_i = 2'b10;
        #1;
        n_tests++;
        if (gnt_o !== 4'b1100) begin n_fail++; $display("FAIL rd_then_wr_gnt: got %b expected %b", gnt_o, 4'b1100); end
        n_tests++;
        if (m_id_o[1][5] !== 1'b1) begin n_fail++; $display("FAIL rd_then_wr_tag: got %b expected %b", m_id_o[1][5], 1'b1); end
        tick();
        clear_inputs();
    endtask

    // Owner 1 locked; partial lane grants and a dropped request must not release it.
    task automatic test_stall_lock();
        pend_i = 2'b10;
        req_i[1] = 2'b11;
        last_i[1] = 2'b00;
        #1;
        n_tests++;
        if (gnt_o !== 4'b1100) begin n_fail++; $display("FAIL stall_start_gnt: got %b expected %b", gnt_o, 4'b1100); end
        tick();
        m_gnt_i = 2'b01;
        pend_i = 2'b01;
        for (int c = 0; c < 3; c++) begin
            req_i[1] = (c == 1) ? 2'b00 : 2'b11;
            last_i[1] = (c == 2) ? 2'b11 : 2'b00;
            #1;
            n_tests++;
            if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL stall_c%0d_gnt: got %b expected %b", c, gnt_o, 4'b0100); end
            tick();
        end
        m_gnt_i = 2'b11;
        req_i[1] = 2'b11;
        last_i[1] = 2'b11;
        pend_i = 2'b11;
        #1;
        n_tests++;
        if (gnt_o !== 4'b1100) begin n_fail++; $display("FAIL stall_resume_gnt: got %b expected %b", gnt_o, 4'b1100); end
        tick();
        clear_inputs();
        pend_i = 2'b01;
        #1;
        n_tests++;
        if (gnt_o !== 4'b0011) begin n_fail++; $display("FAIL stall_release_gnt: got %b expected %b", gnt_o, 4'b0011); end
        pend_i = 2'b00;
    endtask

    // Both pending single beats: strict R,W,R,W with no idle cycles.
    task automatic test_alternate();
        logic exp_owner;
        pend_i = 2'b11;
        req_i = 4'b1111;
        last_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_owner = (k % 2) == 1;
            #1;
            n_tests++;
            if (gnt_o !== (exp_owner ? 4'b1100 : 4'b0011) || m_id_o[0][5] !== exp_owner) begin
                n_fail++;
                $display("FAIL alt_k%0d: got gnt=%b tag=%b expected owner %0d", k, gnt_o, m_id_o[0][5], exp_owner);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_response();
        m_r_req_i = 1'b1;
        m_r_id_i = 6'b100101;
        r_gnt_i = 2'b10;
        #1;
        n_tests++;
        if (r_req_o !== 2'b10) begin n_fail++; $display("FAIL resp_req: got %b expected %b", r_req_o, 2'b10); end
        n_tests++;
        if (r_id_o[1] !== 6'b000101) begin n_fail++; $display("FAIL resp_id: got %b expected %b", r_id_o[1], 6'b000101); end
        n_tests++;
        if (m_r_gnt_o !== 1'b1) begin n_fail++; $display("FAIL resp_gnt_hi: got %b expected %b", m_r_gnt_o, 1'b1); end
        r_gnt_i = 2'b01;
        #1;
        n_tests++;
        if (m_r_gnt_o !== 1'b0) begin n_fail++; $display("FAIL resp_gnt_lo: got %b expected %b", m_r_gnt_o, 1'b0); end
        m_r_id_i = 6'b000011;
        #1;
        n_tests++;
        if (r_req_o !== 2'b01 || m_r_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL resp_rd: got req=%b gnt=%b expected req=01 gnt=1", r_req_o, m_r_gnt_o);
        end
        m_r_req_i = 1'b0;
        r_gnt_i = 2'b00;
    endtask

    // Reset asserted while the write channel holds a lock.
    task automatic test_reset_midburst();
        pend_i = 2'b10;
        req_i[1] = 2'b11;
        last_i[1] = 2'b00;
        tick();
        tick();
        pend_i = 2'b11;
        #1;
        n_tests++;
        if (gnt_o !== 4'b1100) begin n_fail++; $display("FAIL rstmid_pre_gnt: got %b expected %b", gnt_o, 4'b1100); end
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (gnt_o !== 4'b0011) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected %b", gnt_o, 4'b0011); end
        clear_inputs();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

`ifdef AXI2MEM_ARB_PERF_EN
    task automatic test_perf();
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0;
        pend_i = 2'b01;
        req_i[0] = 2'b11;
        for (int b = 0; b < 5; b++) begin
            last_i[0] = (b == 4) ? 2'b11 : 2'b00;
            tick();
        end
        req_i[0] = 2'b00;
        last_i[0] = 2'b00;
        pend_i = 2'b10;
        req_i[1] = 2'b11;
        tick();
        for (int b = 0; b < 3; b++) begin
            last_i[1] = (b == 2) ? 2'b11 : 2'b00;
            tick();
        end
        clear_inputs();
        #1;
        n_tests++;
        if (perf_beats_o[0] !== 32'd5 || perf_beats_o[1] !== 32'd3) begin
            n_fail++; $display("FAIL perf_beats: got %0d/%0d expected 5/3", perf_beats_o[0], perf_beats_o[1]);
        end
        n_tests++;
        if (perf_stall_o !== 32'd1) begin n_fail++; $display("FAIL perf_stall: got %0d expected 1", perf_stall_o); end
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0;
        n_tests++;
        if (perf_beats_o !== 64'd0 || perf_stall_o !== 32'd0) begin
            n_fail++; $display("FAIL perf_clr: got %h/%h expected 0/0", perf_beats_o, perf_stall_o);
        end
    endtask
`endif

    initial begin
        rst_ni = 1'b0;
        pend_i = '0;
        req_i = '0;
        add_i = '0;
        id_i = '0;
        last_i = '0;
        m_gnt_i = 2'b11;
        m_r_req_i = 1'b0;
        m_r_id_i = '0;
        r_gnt_i = '0;
`ifdef AXI2MEM_ARB_PERF_EN
        perf_clr_i = 1'b0;
`endif
        #2;
        test_reset();
        test_write_single();
        test_read_burst();
        test_stall_lock();
        test_alternate();
        test_response();
        test_reset_midburst();
`ifdef AXI2MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
